// File: rtl/uart_rx_byte_writer.sv
// UART receiver with 16x oversampling that pushes each good frame into an async FIFO write port.
// Reports framing, parity and overrun errors as one-cycle pulses.
module uart_rx_byte_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  rx,
  output logic                  fifo_w_en,
  output logic [DATA_WIDTH-1:0] fifo_w_data,
  input  logic                  fifo_w_full,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  state_t                 state_r, state_nxt;
  logic                   rx_meta_r, rx_sync_r;
  logic [DIV_WIDTH-1:0]   tick_cnt_r;
  logic [3:0]             sample_cnt_r;
  logic [BW-1:0]          bit_cnt_r;
  logic [DATA_WIDTH-1:0]  shift_r;
  logic                   par_bad_r;
  logic                   tick_s, clear_s, shift_en_s, par_sample_s, stop_sample_s;

  function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d);
    if (PARITY_ODD != 0) begin
      return ~(^d);
    end else begin
      return ^d;
    end
  endfunction

  assign tick_s = (tick_cnt_r == baud_div);

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // State register
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic and per-state sampling strobes
  always_comb begin
    state_nxt     = state_r;
    shift_en_s    = 1'b0;
    par_sample_s  = 1'b0;
    stop_sample_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_nxt = rx_sync_r ? ST_IDLE : ST_START;
      end
      ST_START: begin
        if (tick_s && (sample_cnt_r == 4'd7)) begin
          state_nxt = rx_sync_r ? ST_IDLE : ST_DATA;
        end else begin
          state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && (sample_cnt_r == 4'd15)) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == LAST_BIT) begin
            state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            state_nxt = ST_DATA;
          end
        end else begin
          state_nxt = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_s && (sample_cnt_r == 4'd15)) begin
          par_sample_s = 1'b1;
          state_nxt    = ST_STOP;
        end else begin
          state_nxt = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (tick_s && (sample_cnt_r == 4'd15)) begin
          stop_sample_s = 1'b1;
          state_nxt     = rx_sync_r ? ST_IDLE : ST_BREAK;
        end else begin
          state_nxt = ST_STOP;
        end
      end
      ST_BREAK: begin
        state_nxt = rx_sync_r ? ST_IDLE : ST_BREAK;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counters restart on every state change so each state times from its own entry edge
  assign clear_s = (state_nxt != state_r) || (state_r == ST_IDLE) || (state_r == ST_BREAK);

  // Oversample tick, sample-within-bit and bit counters
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      tick_cnt_r   <= '0;
      sample_cnt_r <= 4'd0;
      bit_cnt_r    <= '0;
    end else if (clear_s) begin
      tick_cnt_r   <= '0;
      sample_cnt_r <= 4'd0;
      bit_cnt_r    <= '0;
    end else begin
      tick_cnt_r   <= tick_s ? '0 : (tick_cnt_r + DIV_WIDTH'(1));
      sample_cnt_r <= tick_s ? (sample_cnt_r + 4'd1) : sample_cnt_r;
      bit_cnt_r    <= shift_en_s ? (bit_cnt_r + BW'(1)) : bit_cnt_r;
    end
  end

  // LSB-first deserialiser and latched parity mismatch
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      shift_r   <= '0;
      par_bad_r <= 1'b0;
    end else begin
      if (shift_en_s) begin
        shift_r <= {rx_sync_r, shift_r[DATA_WIDTH-1:1]};
      end else begin
        shift_r <= shift_r;
      end
      if (state_r == ST_IDLE) begin
        par_bad_r <= 1'b0;
      end else if (par_sample_s) begin
        par_bad_r <= (rx_sync_r != expected_parity(shift_r));
      end else begin
        par_bad_r <= par_bad_r;
      end
    end
  end

  // Registered FIFO write strobe, data and status pulses
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      fifo_w_en   <= 1'b0;
      fifo_w_data <= '0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      fifo_w_en   <= stop_sample_s && rx_sync_r && !par_bad_r && !fifo_w_full;
      overrun_err <= stop_sample_s && rx_sync_r && !par_bad_r && fifo_w_full;
      parity_err  <= stop_sample_s && par_bad_r;
      frame_err   <= stop_sample_s && !rx_sync_r;
      busy        <= (state_nxt != ST_IDLE);
      if (stop_sample_s && rx_sync_r && !par_bad_r && !fifo_w_full) begin
        fifo_w_data <= shift_r;
      end else begin
        fifo_w_data <= fifo_w_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte_writer.sv
// Bench for uart_rx_byte_writer: one 8N1 and one 8E1 instance driven by directed and random frames,
// checked against a frame-level outcome model with expected write cycles.
module tb_uart_rx_byte_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic [1:0] rx = 2'b11;
  logic [1:0] full = 2'b00;
  logic [1:0] w_en, fe, pe, oe, busy;
  logic [7:0] wdata0, wdata1;

  int T = 4;
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct { int dut; int data; int cyc; } wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];
  int got_wr[2], got_fe[2], got_pe[2], got_oe[2], dbl[2];
  int exp_wr[2], exp_fe[2], exp_pe[2], exp_oe[2];
  int exp_data[2];
  int rise_cyc[2], fall_cyc[2];
  logic [1:0] prev_en = 2'b00;
  logic [1:0] prev_busy = 2'b00;

  uart_rx_byte_writer #(.DATA_WIDTH(8), .DIV_WIDTH(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .w_clk(clk), .w_rst_n(rst_n), .baud_div(baud_div), .rx(rx[0]),
    .fifo_w_en(w_en[0]), .fifo_w_data(wdata0), .fifo_w_full(full[0]),
    .frame_err(fe[0]), .parity_err(pe[0]), .overrun_err(oe[0]), .busy(busy[0]));

  uart_rx_byte_writer #(.DATA_WIDTH(8), .DIV_WIDTH(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .w_clk(clk), .w_rst_n(rst_n), .baud_div(baud_div), .rx(rx[1]),
    .fifo_w_en(w_en[1]), .fifo_w_data(wdata1), .fifo_w_full(full[1]),
    .frame_err(fe[1]), .parity_err(pe[1]), .overrun_err(oe[1]), .busy(busy[1]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (w_en[d]) begin
        got_q.push_back('{d, (d == 0) ? int'(wdata0) : int'(wdata1), cyc});
        got_wr[d] <= got_wr[d] + 1;
      end
      if (w_en[d] && prev_en[d]) dbl[d] <= dbl[d] + 1;
      if (fe[d]) got_fe[d] <= got_fe[d] + 1;
      if (pe[d]) got_pe[d] <= got_pe[d] + 1;
      if (oe[d]) got_oe[d] <= got_oe[d] + 1;
      if (busy[d] && !prev_busy[d]) rise_cyc[d] <= cyc;
      if (!busy[d] && prev_busy[d]) fall_cyc[d] <= cyc;
    end
    prev_en   <= w_en;
    prev_busy <= busy;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: outcome decided from line bits and full flag; write lands at stop-sample edge
  task automatic model(input int d, input logic [7:0] data, input logic pbit, input logic sbit,
                       input logic f, input int start);
    logic mism;
    mism = (d == 1) && (pbit != ($countones(data) % 2 == 1));
    if (!sbit) begin
      exp_fe[d]++;
      if (mism) exp_pe[d]++;
    end else if (mism) begin
      exp_pe[d]++;
    end else if (f) begin
      exp_oe[d]++;
    end else begin
      exp_wr[d]++;
      exp_data[d] = data;
      exp_q.push_back('{d, int'(data), start + 3 + T * (8 + 16 * (9 + d))});
    end
  endtask

  task automatic send_frame(input int d, input logic [7:0] data, input logic pbit,
                            input logic sbit, input logic f);
    int bp;
    bp = 16 * T;
    full[d] = f;
    model(d, data, pbit, sbit, f, cyc);
    rx[d] = 1'b0;
    wait_cyc(bp);
    for (int b = 0; b < 8; b++) begin
      rx[d] = data[b];
      wait_cyc(bp);
    end
    if (d == 1) begin
      rx[d] = pbit;
      wait_cyc(bp);
    end
    rx[d] = sbit;
    wait_cyc(bp);
  endtask

  task automatic check_all(input int d, input string tag);
    wr_t g, e;
    check({tag, "/wr_cnt"}, got_wr[d], exp_wr[d]);
    check({tag, "/fe_cnt"}, got_fe[d], exp_fe[d]);
    check({tag, "/pe_cnt"}, got_pe[d], exp_pe[d]);
    check({tag, "/oe_cnt"}, got_oe[d], exp_oe[d]);
    check({tag, "/dbl_wr"}, dbl[d], 32'd0);
    check({tag, "/wq_len"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "/wr_dut"}, g.dut, e.dut);
      check({tag, "/wr_data"}, g.data, e.data);
      check({tag, "/wr_cyc"}, g.cyc, e.cyc);
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "/data_hold"}, (d == 0) ? wdata0 : wdata1, exp_data[d]);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "/w_en"}, w_en, 2'b00);
    check({tag, "/fe"}, fe, 2'b00);
    check({tag, "/pe"}, pe, 2'b00);
    check({tag, "/oe"}, oe, 2'b00);
    check({tag, "/busy"}, busy, 2'b00);
    check({tag, "/wdata0"}, wdata0, 8'h00);
    check({tag, "/wdata1"}, wdata1, 8'h00);
  endtask

  initial begin
    int s;
    logic [7:0] rd;
    logic rp, rs, rf;
    int d;

    wait_cyc(3);
    check_reset("reset");
    rst_n = 1'b1;
    wait_cyc(5);

    // 8N1 good frame with busy rise/fall timing
    s = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0);
    check("a5/busy_rise", rise_cyc[0], s + 3);
    check("a5/busy_fall", fall_cyc[0], s + 611);
    check_all(0, "a5");

    // Back-to-back frames, no idle gap
    send_frame(0, 8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0);
    check_all(0, "b2b");

    // Even parity: wrong then right parity bit for 0x07
    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b0);
    wait_cyc(4);
    check_all(1, "par_bad");
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0);
    wait_cyc(4);
    check_all(1, "par_ok");

    // Framing error followed by a long break
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0);
    wait_cyc(2500);
    check("brk/busy_mid", busy[0], 1'b1);
    wait_cyc(2500);
    check("brk/busy_end", busy[0], 1'b1);
    rx[0] = 1'b1;
    wait_cyc(6);
    check("brk/busy_after", busy[0], 1'b0);
    check_all(0, "brk");

    // Overrun then recovery
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1);
    wait_cyc(4);
    check_all(0, "ovr");
    send_frame(0, 8'h66, 1'b0, 1'b1, 1'b0);
    wait_cyc(4);
    check_all(0, "ovr_rec");

    // Short glitch on the idle line
    rx[0] = 1'b0;
    wait_cyc(20);
    rx[0] = 1'b1;
    wait_cyc(60);
    check("glitch/busy", busy[0], 1'b0);
    check_all(0, "glitch");

    // Reset in the middle of a data bit
    rx[0] = 1'b0;
    wait_cyc(16 * T * 3 + 20);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    exp_data[0] = 0;
    exp_data[1] = 0;
    wait_cyc(2);
    rx[0] = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    check_all(0, "mid_rst");
    send_frame(0, 8'h9E, 1'b0, 1'b1, 1'b0);
    wait_cyc(4);
    check_all(0, "post_rst");

    // Randomised frames on both instances
    for (int i = 0; i < 10; i++) begin
      d  = int'($urandom_range(0, 1));
      rd = 8'($urandom_range(0, 255));
      rf = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 5) != 0);
      rp = (($countones(rd) % 2) == 1) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, rd, (d == 1) ? rp : 1'b0, rs, rf);
      if (!rs) begin
        rx[d] = 1'b1;
        wait_cyc(8);
      end else begin
        wait_cyc(int'($urandom_range(1, 20)));
      end
      check_all(d, "rand");
    end

    // Slower oversample rate
    T = 8;
    baud_div = 16'd7;
    wait_cyc(4);
    s = cyc;
    send_frame(1, 8'h5A, 1'b0, 1'b1, 1'b0);
    check("t8/busy_fall", fall_cyc[1], s + 3 + 8 * (8 + 16 * 10));
    check_all(1, "t8");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
